// File: rtl/fp_rf_pkg.sv
// fp_rf_pkg: shared constants, helper and types for the multi-port FP register file.
//   RF_DATA_W / RF_NUM_REGS / RF_NUM_RD : default configuration
//   rf_aw(n)                            : address width for n registers
//   rf_addr_t                           : register address for the default configuration
package fp_rf_pkg;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_NUM_RD   = 3;

  // Address width needed to index n registers.
  function automatic int unsigned rf_aw(input int unsigned n);
    return $clog2(n);
  endfunction

  typedef logic [4:0] rf_addr_t;

endpackage

// File: rtl/fp_rf_scoreboard.sv
// fp_rf_scoreboard: per-register pending-write tracker for the register file.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   issue_en, issue_reg    : an issuing instruction marks its destination busy
//   we0/waddr0, we1/waddr1 : writeback ports; a writeback clears the busy bit
//   raddr                  : packed read addresses, NUM_RD x AW
//   busy_vec               : registered busy bits, one per register
//   rbusy                  : combinational busy flag per read port
module fp_rf_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned R0_ZERO  = 0,
  localparam int unsigned AW      = rf_aw(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_reg,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [NUM_RD-1:0]    rbusy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_next;
  logic [AW-1:0]       w_ra;

  // Per-register set (issue) and clear (writeback) decode.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      w_set[i] = issue_en && (issue_reg == AW'(i)) && !((R0_ZERO != 0) && (i == 0));
      w_clr[i] = (we0 && (waddr0 == AW'(i))) || (we1 && (waddr1 == AW'(i)));
    end
  end

  // Set beats clear: a newly issued producer supersedes the retiring write.
  assign w_next = w_set | (~w_clr & r_busy);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_next;
    end
  end

  assign busy_vec = r_busy;

  // Read-port busy; with bypass a same-cycle writeback already frees the operand.
  always_comb begin
    rbusy = '0;
    w_ra  = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      w_ra     = raddr[k*AW +: AW];
      rbusy[k] = r_busy[w_ra] && !((BYPASS != 0) && w_clr[w_ra]);
      if ((R0_ZERO != 0) && (w_ra == '0)) begin
        rbusy[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_reg_file_mp.sv
// fp_reg_file_mp: parametrised multi-port register file with two write ports,
// NUM_RD read ports, optional write-to-read bypass, optional zero register 0
// and a busy scoreboard for decode stalls.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   we0/waddr0/wdata0      : write port 0 (ALU/FPU writeback)
//   we1/waddr1/wdata1      : write port 1 (load writeback), wins on address clash
//   raddr                  : packed read addresses, port k at [k*AW +: AW]
//   rdata                  : packed combinational read data, port k at [k*DATA_W +: DATA_W]
//   rbusy                  : combinational busy flag per read port
//   issue_en, issue_reg    : destination of an instruction issued this cycle
//   busy_vec               : registered scoreboard, one bit per register
module fp_reg_file_mp
  import fp_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned R0_ZERO  = 0,
  localparam int unsigned AW      = rf_aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we0,
  input  logic [AW-1:0]            waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [AW-1:0]            waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_reg,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr0;
  logic              w_wr1;
  logic [AW-1:0]     w_ra;
  logic [DATA_W-1:0] w_rd;

  // In integer mode register 0 is hardwired, so writes to it are dropped.
  assign w_wr0 = we0 && !((R0_ZERO != 0) && (waddr0 == '0));
  assign w_wr1 = we1 && !((R0_ZERO != 0) && (waddr1 == '0));

  // Storage; port 1 is assigned last so it wins when both ports hit one register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr0) begin
        r_mem[waddr0] <= wdata0;
      end
      if (w_wr1) begin
        r_mem[waddr1] <= wdata1;
      end
    end
  end

  // Read muxing with optional bypass (port 1 checked last for priority).
  always_comb begin
    rdata = '0;
    w_ra  = '0;
    w_rd  = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      w_ra = raddr[k*AW +: AW];
      w_rd = r_mem[w_ra];
      if (BYPASS != 0) begin
        if (we0 && (waddr0 == w_ra)) begin
          w_rd = wdata0;
        end
        if (we1 && (waddr1 == w_ra)) begin
          w_rd = wdata1;
        end
      end
      if ((R0_ZERO != 0) && (w_ra == '0)) begin
        w_rd = '0;
      end
      rdata[k*DATA_W +: DATA_W] = w_rd;
    end
  end

  fp_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .R0_ZERO  (R0_ZERO)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue_en  (issue_en),
    .issue_reg (issue_reg),
    .we0       (we0),
    .waddr0    (waddr0),
    .we1       (we1),
    .waddr1    (waddr1),
    .raddr     (raddr),
    .busy_vec  (busy_vec),
    .rbusy     (rbusy)
  );

endmodule

// File: doc/fp_reg_file_mp.md
Name: fp_reg_file_mp

Overview:
- Parametrised multi-port register file for the MIPS32 floating-point DSP datapath. Successor to the fixed 32x32, 3-read/1-write file.
- Adds two write ports (ALU/FPU writeback plus load writeback) and N configurable read ports.
- Adds optional same-cycle write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard so decode can stall on pending writes.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (power of 2, >=4)
- NUM_RD, 3, number of read ports (1..6)
- BYPASS, 1, 1 = read data and busy flags reflect same-cycle writes; 0 = registered contents only
- R0_ZERO, 0, 1 = register 0 reads 0, ignores writes, never busy (integer mode); 0 = register 0 is ordinary (FP mode)
- AW, $clog2(NUM_REGS), derived address width (localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- we0  in  1  write port 0 enable (ALU/FPU writeback)
- waddr0  in  AW  write port 0 address
- wdata0  in  DATA_W  write port 0 data
- we1  in  1  write port 1 enable (load writeback)
- waddr1  in  AW  write port 1 address
- wdata1  in  DATA_W  write port 1 data
- raddr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rbusy  out  NUM_RD  busy flag of each read address, combinational
- issue_en  in  1  an instruction with a destination is issued this cycle
- issue_reg  in  AW  destination register of the issuing instruction
- busy_vec  out  NUM_REGS  registered scoreboard, bit i = register i has a pending write

Behaviour:
- Reset: when reset_n is sampled 0 at a clock edge, all registers and all busy_vec bits clear to 0 in that cycle. This overrides any write or issue in the same cycle. rdata reads 0 on the cycle after reset.
- Write: on the clock edge, register[waddrX] <= wdataX when weX=1. Latency is 1 cycle to storage.
- Write-port conflict: if we0 and we1 are both set and waddr0 == waddr1, port 1 wins for the data. Busy still clears.
- Read, BYPASS=0: rdata[k] = stored register[raddr[k]].
- Read, BYPASS=1: if weX and waddrX == raddr[k], rdata[k] = wdataX, with port 1 having priority over port 0. Otherwise rdata[k] is the stored value.
- R0_ZERO=1: reads of register 0 return 0 regardless of bypass. Writes to register 0 are dropped. issue_reg=0 does not set busy.
- Scoreboard update per register i on each edge (outside reset):
  - set = issue_en && issue_reg==i
  - clr = (we0 && waddr0==i) || (we1 && waddr1==i)
  - next = set ? 1 : (clr ? 0 : busy). Set wins over clear, because a newer producer supersedes the retiring write (WAW).
- Writes to a non-busy register are legal. Data is written and busy stays 0.
- Issue to an already-busy register keeps busy at 1. There is no counting; the pipeline guarantees in-order writeback per register.
- rbusy[k]:
  - BYPASS=1: busy_vec[raddr[k]] && !clr(raddr[k]), i.e. a same-cycle writeback frees the read.
  - BYPASS=0: busy_vec[raddr[k]].
  - R0_ZERO=1 forces rbusy=0 for address 0.
- No X propagation: all storage is initialised by reset. No latches.

Decomposition:
- Package fp_rf_pkg holds:
  - default constants RF_DATA_W=32, RF_NUM_REGS=32, RF_NUM_RD=3
  - function rf_aw(n) returning $clog2(n)
  - typedef rf_addr_t (logic [4:0]) for the default configuration
- Sub-module fp_rf_scoreboard owns busy_vec:
  - inputs: clk, reset_n, issue, the two writeback ports (enable+address), NUM_RD read addresses
  - outputs: busy_vec, rbusy
  - the top-level file holds storage and read muxing only.

Test Plan:
- Reset then read all: drive reset_n=0 for 1 cycle after writing 0xDEADBEEF to register 5 -> register 5 and busy_vec read 0 the next cycle.
- Dual write conflict: we0=1 waddr0=7 wdata0=0x11111111 and we1=1 waddr1=7 wdata1=0x22222222 -> register 7 = 0x22222222. Repeat with waddr1=8 -> register 7 = 0x11111111, register 8 = 0x22222222.
- Bypass: BYPASS=1, write 0x3F800000 to register 3 while raddr port 2 = 3 -> rdata port 2 = 0x3F800000 in the same cycle. With BYPASS=0 -> old value that cycle, new value the next cycle.
- Scoreboard: issue_reg=9 -> busy_vec[9]=1 the next cycle and rbusy=1 for any port reading 9. Write register 9 -> rbusy=0 that cycle (BYPASS=1) and busy_vec[9]=0 after the edge.
- Set/clear collision: busy_vec[4]=1, same cycle issue_reg=4 and we1 waddr1=4 -> busy_vec[4] stays 1 and register 4 takes wdata1.
- R0_ZERO=1: write 0xFFFFFFFF to register 0 and issue_reg=0 -> rdata=0, rbusy=0, busy_vec[0]=0. With R0_ZERO=0 -> register 0 reads 0xFFFFFFFF and busy_vec[0]=1.
